// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 scan-code-set-2 decoder: prefix bytes,
// modifier scan codes, discard list, FSM encoding and mods bit positions.
package ps2_kbd_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_ALT      = 8'h11;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  // Bytes still to swallow after E1 (rest of the Pause make/break sequence).
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int MOD_SHIFT = 0;
  localparam int MOD_CTRL  = 1;
  localparam int MOD_ALT   = 2;
  localparam int MOD_CAPS  = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PROC = 1'b1
  } dec_state_e;

  // Keyboard protocol replies and error bytes that carry no key meaning.
  function automatic logic is_discard(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// US-layout scan-code-set-2 to ASCII translation, purely combinational.
// Break handling is done by the caller; this only maps make codes.
module ps2_ascii_lut
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  input  logic       shift_i,
  input  logic       caps_i,
  input  logic       ctrl_i,
  output logic [7:0] ascii_o
);

  logic       letter;
  logic [7:0] base;
  logic [7:0] shifted;

  // Table lookup: letters give their lowercase form, others give base/shifted pair.
  always_comb begin
    letter  = 1'b0;
    base    = 8'h00;
    shifted = 8'h00;
    case (code_i)
      8'h1C: begin letter = 1'b1; base = 8'h61; end
      8'h32: begin letter = 1'b1; base = 8'h62; end
      8'h21: begin letter = 1'b1; base = 8'h63; end
      8'h23: begin letter = 1'b1; base = 8'h64; end
      8'h24: begin letter = 1'b1; base = 8'h65; end
      8'h2B: begin letter = 1'b1; base = 8'h66; end
      8'h34: begin letter = 1'b1; base = 8'h67; end
      8'h33: begin letter = 1'b1; base = 8'h68; end
      8'h43: begin letter = 1'b1; base = 8'h69; end
      8'h3B: begin letter = 1'b1; base = 8'h6A; end
      8'h42: begin letter = 1'b1; base = 8'h6B; end
      8'h4B: begin letter = 1'b1; base = 8'h6C; end
      8'h3A: begin letter = 1'b1; base = 8'h6D; end
      8'h31: begin letter = 1'b1; base = 8'h6E; end
      8'h44: begin letter = 1'b1; base = 8'h6F; end
      8'h4D: begin letter = 1'b1; base = 8'h70; end
      8'h15: begin letter = 1'b1; base = 8'h71; end
      8'h2D: begin letter = 1'b1; base = 8'h72; end
      8'h1B: begin letter = 1'b1; base = 8'h73; end
      8'h2C: begin letter = 1'b1; base = 8'h74; end
      8'h3C: begin letter = 1'b1; base = 8'h75; end
      8'h2A: begin letter = 1'b1; base = 8'h76; end
      8'h1D: begin letter = 1'b1; base = 8'h77; end
      8'h22: begin letter = 1'b1; base = 8'h78; end
      8'h35: begin letter = 1'b1; base = 8'h79; end
      8'h1A: begin letter = 1'b1; base = 8'h7A; end
      8'h45: begin base = 8'h30; shifted = 8'h29; end
      8'h16: begin base = 8'h31; shifted = 8'h21; end
      8'h1E: begin base = 8'h32; shifted = 8'h40; end
      8'h26: begin base = 8'h33; shifted = 8'h23; end
      8'h25: begin base = 8'h34; shifted = 8'h24; end
      8'h2E: begin base = 8'h35; shifted = 8'h25; end
      8'h36: begin base = 8'h36; shifted = 8'h5E; end
      8'h3D: begin base = 8'h37; shifted = 8'h26; end
      8'h3E: begin base = 8'h38; shifted = 8'h2A; end
      8'h46: begin base = 8'h39; shifted = 8'h28; end
      8'h0E: begin base = 8'h60; shifted = 8'h7E; end
      8'h4E: begin base = 8'h2D; shifted = 8'h5F; end
      8'h55: begin base = 8'h3D; shifted = 8'h2B; end
      8'h54: begin base = 8'h5B; shifted = 8'h7B; end
      8'h5B: begin base = 8'h5D; shifted = 8'h7D; end
      8'h5D: begin base = 8'h5C; shifted = 8'h7C; end
      8'h4C: begin base = 8'h3B; shifted = 8'h3A; end
      8'h52: begin base = 8'h27; shifted = 8'h22; end
      8'h41: begin base = 8'h2C; shifted = 8'h3C; end
      8'h49: begin base = 8'h2E; shifted = 8'h3E; end
      8'h4A: begin base = 8'h2F; shifted = 8'h3F; end
      8'h29: begin base = 8'h20; shifted = 8'h20; end
      8'h5A: begin base = 8'h0D; shifted = 8'h0D; end
      8'h66: begin base = 8'h08; shifted = 8'h08; end
      8'h0D: begin base = 8'h09; shifted = 8'h09; end
      8'h76: begin base = 8'h1B; shifted = 8'h1B; end
      default: begin base = 8'h00; shifted = 8'h00; end
    endcase
  end

  // Apply modifiers; extended keys only map keypad Enter and keypad slash.
  always_comb begin
    ascii_o = 8'h00;
    if (ext_i) begin
      if (code_i == SC_ENTER) begin
        ascii_o = 8'h0D;
      end else if (code_i == SC_KP_SLASH) begin
        ascii_o = 8'h2F;
      end
    end else if (letter) begin
      if (ctrl_i) begin
        ascii_o = base - 8'h60;
      end else if (shift_i ^ caps_i) begin
        ascii_o = base - 8'h20;
      end else begin
        ascii_o = base;
      end
    end else begin
      ascii_o = shift_i ? shifted : base;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops scan-code set 2 bytes from the PS/2 receiver FIFO, resolves E0/F0/E1
// prefixes, tracks modifier state and emits key events over valid/ready.
//
//   state  | meaning
//   S_IDLE | wait for a byte and room in the event register, then pop it
//   S_PROC | release the pop strobe and decode the captured byte
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter bit EMIT_BREAK     = 1'b1,
  parameter bit EMIT_MODIFIERS = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  output logic       kbd_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] evt_ascii,
  output logic [3:0] mods
);

  dec_state_e state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic       shift_l_q, shift_l_d;
  logic       shift_r_q, shift_r_d;
  logic       ctrl_l_q, ctrl_l_d;
  logic       ctrl_r_q, ctrl_r_d;
  logic       alt_l_q, alt_l_d;
  logic       alt_r_q, alt_r_d;
  logic       caps_lock_q, caps_lock_d;
  logic       caps_held_q, caps_held_d;
  logic       evt_valid_q, evt_valid_d;
  logic [7:0] evt_code_q, evt_code_d;
  logic       evt_ext_q, evt_ext_d;
  logic       evt_break_q, evt_break_d;
  logic [7:0] evt_ascii_q, evt_ascii_d;

  logic       shift_now;
  logic       ctrl_now;
  logic       alt_now;
  logic       is_mod;
  logic       emit;
  logic [7:0] lut_ascii;

  assign shift_now = shift_l_q | shift_r_q;
  assign ctrl_now  = ctrl_l_q | ctrl_r_q;
  assign alt_now   = alt_l_q | alt_r_q;

  // E0 12 / E0 59 are fake shifts in some sequences, so only plain codes count.
  assign is_mod = (!ext_q && (code_q == SC_LSHIFT || code_q == SC_RSHIFT ||
                              code_q == SC_CAPS)) ||
                  code_q == SC_CTRL || code_q == SC_ALT;
  assign emit   = (!brk_q || EMIT_BREAK) && (!is_mod || EMIT_MODIFIERS);

  ps2_ascii_lut u_lut (
    .code_i  (code_q),
    .ext_i   (ext_q),
    .shift_i (shift_now),
    .caps_i  (caps_lock_q),
    .ctrl_i  (ctrl_now),
    .ascii_o (lut_ascii)
  );

  // State, prefix, modifier and event registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      code_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      skip_q       <= 3'd0;
      shift_l_q    <= 1'b0;
      shift_r_q    <= 1'b0;
      ctrl_l_q     <= 1'b0;
      ctrl_r_q     <= 1'b0;
      alt_l_q      <= 1'b0;
      alt_r_q      <= 1'b0;
      caps_lock_q  <= 1'b0;
      caps_held_q  <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 8'h00;
      evt_ext_q    <= 1'b0;
      evt_break_q  <= 1'b0;
      evt_ascii_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      nextdata_n_q <= nextdata_n_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      skip_q       <= skip_d;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
      ctrl_l_q     <= ctrl_l_d;
      ctrl_r_q     <= ctrl_r_d;
      alt_l_q      <= alt_l_d;
      alt_r_q      <= alt_r_d;
      caps_lock_q  <= caps_lock_d;
      caps_held_q  <= caps_held_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_ext_q    <= evt_ext_d;
      evt_break_q  <= evt_break_d;
      evt_ascii_q  <= evt_ascii_d;
    end
  end

  // Next-state: pop in S_IDLE, decode in S_PROC; an accepted event retires
  // on the same edge a new one may load.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    nextdata_n_d = 1'b1;
    ext_d        = ext_q;
    brk_d        = brk_q;
    skip_d       = skip_q;
    shift_l_d    = shift_l_q;
    shift_r_d    = shift_r_q;
    ctrl_l_d     = ctrl_l_q;
    ctrl_r_d     = ctrl_r_q;
    alt_l_d      = alt_l_q;
    alt_r_d      = alt_r_q;
    caps_lock_d  = caps_lock_q;
    caps_held_d  = caps_held_q;
    evt_valid_d  = evt_valid_q & ~evt_ready;
    evt_code_d   = evt_code_q;
    evt_ext_d    = evt_ext_q;
    evt_break_d  = evt_break_q;
    evt_ascii_d  = evt_ascii_q;

    case (state_q)
      S_IDLE: begin
        if (kbd_ready && (!evt_valid_q || evt_ready)) begin
          code_d       = kbd_data;
          nextdata_n_d = 1'b0;
          state_d      = S_PROC;
        end
      end
      S_PROC: begin
        state_d = S_IDLE;
        if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
        end else if (code_q == PFX_E1) begin
          skip_d = PAUSE_SKIP;
        end else if (code_q == PFX_E0) begin
          ext_d = 1'b1;
        end else if (code_q == PFX_F0) begin
          brk_d = 1'b1;
        end else if (!is_discard(code_q)) begin
          if (!ext_q && code_q == SC_LSHIFT) shift_l_d = !brk_q;
          if (!ext_q && code_q == SC_RSHIFT) shift_r_d = !brk_q;
          if (code_q == SC_CTRL) begin
            if (ext_q) ctrl_r_d = !brk_q;
            else       ctrl_l_d = !brk_q;
          end
          if (code_q == SC_ALT) begin
            if (ext_q) alt_r_d = !brk_q;
            else       alt_l_d = !brk_q;
          end
          if (!ext_q && code_q == SC_CAPS) begin
            if (brk_q) begin
              caps_held_d = 1'b0;
            end else begin
              if (!caps_held_q) caps_lock_d = !caps_lock_q;
              caps_held_d = 1'b1;
            end
          end
          if (emit) begin
            evt_valid_d = 1'b1;
            evt_code_d  = code_q;
            evt_ext_d   = ext_q;
            evt_break_d = brk_q;
            evt_ascii_d = brk_q ? 8'h00 : lut_ascii;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Live modifier view packed into the documented bit positions.
  always_comb begin
    mods            = 4'b0000;
    mods[MOD_SHIFT] = shift_now;
    mods[MOD_CTRL]  = ctrl_now;
    mods[MOD_ALT]   = alt_now;
    mods[MOD_CAPS]  = caps_lock_q;
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign evt_valid      = evt_valid_q;
  assign evt_code       = evt_code_q;
  assign evt_ext        = evt_ext_q;
  assign evt_break      = evt_break_q;
  assign evt_ascii      = evt_ascii_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench: a keyboard-level reference model predicts events as bytes
// are queued into a modelled receiver FIFO; a monitor checks DUT events.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_ready = 1'b0;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] evt_ascii;
  logic [3:0] mods;

  ps2_scancode_decoder #(.EMIT_BREAK(1'b1), .EMIT_MODIFIERS(1'b1)) dut (
    .clk            (clk),
    .clr            (clr),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_break      (evt_break),
    .evt_ascii      (evt_ascii),
    .mods           (mods)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic [3:0] mods;
  } evt_t;

  logic [7:0] rxq[$];
  evt_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         ready_mode = 0;

  // Reference keyboard state
  bit m_ext, m_brk, m_shl, m_shr, m_ctl, m_ctr, m_all, m_alr, m_caps, m_caps_held;
  int m_skip;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sym_codes [21] = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h54,
                                 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] sym_lo [21] = '{8'h60, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                              8'h37, 8'h38, 8'h39, 8'h30, 8'h2D, 8'h3D, 8'h5B,
                              8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] sym_hi [21] = '{8'h7E, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
                              8'h26, 8'h2A, 8'h28, 8'h29, 8'h5F, 8'h2B, 8'h7B,
                              8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

  function automatic logic [3:0] m_mods();
    return {m_caps, m_all | m_alr, m_ctl | m_ctr, m_shl | m_shr};
  endfunction

  function automatic logic [7:0] ref_ascii(logic [7:0] c, bit ext, bit sh, bit cp, bit ct);
    if (ext) return (c == 8'h5A) ? 8'h0D : (c == 8'h4A) ? 8'h2F : 8'h00;
    for (int i = 0; i < 26; i++) begin
      if (letter_codes[i] == c) begin
        if (ct) return 8'(i + 1);
        if (sh ^ cp) return 8'(8'h41 + i);
        return 8'(8'h61 + i);
      end
    end
    for (int i = 0; i < 21; i++) begin
      if (sym_codes[i] == c) return sh ? sym_hi[i] : sym_lo[i];
    end
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    {m_ext, m_brk, m_shl, m_shr, m_ctl, m_ctr, m_all, m_alr, m_caps, m_caps_held} = '0;
    m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] asc;
    bit make;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
    end else begin
      make = !m_brk;
      asc = m_brk ? 8'h00 : ref_ascii(b, m_ext, m_shl | m_shr, m_caps, m_ctl | m_ctr);
      if (!m_ext && b == 8'h12) m_shl = make;
      if (!m_ext && b == 8'h59) m_shr = make;
      if (b == 8'h14) begin if (m_ext) m_ctr = make; else m_ctl = make; end
      if (b == 8'h11) begin if (m_ext) m_alr = make; else m_all = make; end
      if (!m_ext && b == 8'h58) begin
        if (make && !m_caps_held) m_caps = !m_caps;
        m_caps_held = make;
      end
      exp_q.push_back('{b, m_ext, m_brk, asc, m_mods()});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    model_byte(b);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver FIFO model: pops on each strobe, checks strobe width and underflow.
  bit pop_prev = 0;
  always @(negedge clk) begin
    if (clr) begin
      pop_prev = 0;
    end else begin
      if (!kbd_nextdata_n) begin
        n_checks++;
        if (pop_prev || rxq.size() == 0) begin
          n_fail++;
          $display("FAIL pop_strobe: low_prev_cycle=%0b fifo_size=%0d, required single-cycle pop of non-empty FIFO",
                   pop_prev, rxq.size());
        end
        if (rxq.size() > 0) void'(rxq.pop_front());
      end
      pop_prev = !kbd_nextdata_n;
    end
    kbd_ready = (rxq.size() > 0);
    kbd_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  // Event monitor: compare transferred events, check stability while stalled.
  bit stall_prev = 0;
  logic [7:0] p_code, p_ascii;
  logic p_ext, p_brk;
  always @(negedge clk) begin
    evt_t e;
    if (clr) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        n_checks++;
        if (!evt_valid || evt_code !== p_code || evt_ascii !== p_ascii ||
            evt_ext !== p_ext || evt_break !== p_brk) begin
          n_fail++;
          $display("FAIL evt_stable: valid=%0b code=%h ascii=%h ext=%0b brk=%0b, required held code=%h ascii=%h ext=%0b brk=%0b",
                   evt_valid, evt_code, evt_ascii, evt_ext, evt_break, p_code, p_ascii, p_ext, p_brk);
        end
      end
      if (evt_valid && evt_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL evt_unexpected: code=%h ext=%0b brk=%0b ascii=%h, no event expected",
                   evt_code, evt_ext, evt_break, evt_ascii);
        end else begin
          e = exp_q.pop_front();
          if (evt_code !== e.code || evt_ext !== e.ext || evt_break !== e.brk ||
              evt_ascii !== e.ascii || mods !== e.mods) begin
            n_fail++;
            $display("FAIL evt: got code=%h ext=%0b brk=%0b ascii=%h mods=%b, expected code=%h ext=%0b brk=%0b ascii=%h mods=%b",
                     evt_code, evt_ext, evt_break, evt_ascii, mods,
                     e.code, e.ext, e.brk, e.ascii, e.mods);
          end
        end
      end
      stall_prev = evt_valid && !evt_ready;
      p_code  = evt_code;
      p_ascii = evt_ascii;
      p_ext   = evt_ext;
      p_brk   = evt_break;
    end
  end

  // Consumer ready: always, never, or random.
  initial begin
    evt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       evt_ready = 1'b1;
        1:       evt_ready = 1'b0;
        default: evt_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic drain();
    int t = 0;
    while ((rxq.size() != 0 || exp_q.size() != 0) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_fifo", rxq.size(), 0);
    chk("drain_events", exp_q.size(), 0);
    chk("mods_model", {28'd0, mods}, {28'd0, m_mods()});
  endtask

  task automatic rand_token();
    logic [7:0] c;
    int r = $urandom_range(0, 9);
    logic [7:0] modc [5] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
    logic [7:0] spc  [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] extc [5] = '{8'h5A, 8'h4A, 8'h75, 8'h6B, 8'h71};
    logic [7:0] disc [6] = '{8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] unm  [4] = '{8'h05, 8'h7E, 8'h77, 8'h6C};
    case (r)
      0, 1, 2: begin
        c = letter_codes[$urandom_range(0, 25)];
        if ($urandom_range(0, 2) == 0) send(8'hF0);
        send(c);
      end
      3: begin
        c = sym_codes[$urandom_range(0, 20)];
        if ($urandom_range(0, 2) == 0) send(8'hF0);
        send(c);
      end
      4: begin
        c = modc[$urandom_range(0, 4)];
        if ((c == 8'h14 || c == 8'h11) && $urandom_range(0, 1) == 1) send(8'hE0);
        if ($urandom_range(0, 1) == 1) send(8'hF0);
        send(c);
      end
      5: send(spc[$urandom_range(0, 4)]);
      6: begin
        send(8'hE0);
        if ($urandom_range(0, 2) == 0) send(8'hF0);
        send(extc[$urandom_range(0, 4)]);
      end
      7: send(disc[$urandom_range(0, 5)]);
      8: send(unm[$urandom_range(0, 3)]);
      default: begin
        if ($urandom_range(0, 4) == 0) begin
          send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
          send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        end else begin
          send(letter_codes[$urandom_range(0, 25)]);
        end
      end
    endcase
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_nextdata_n", kbd_nextdata_n, 1);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", evt_code, 0);
    chk("rst_evt_ascii", evt_ascii, 0);
    chk("rst_evt_flags", {evt_ext, evt_break}, 0);
    chk("rst_mods", mods, 0);
    @(posedge clk);
    #2 clr = 1'b0;

    // Single make code, with capture-to-valid latency
    send(8'h1C);
    begin
      int t = 0;
      @(negedge clk);
      while (kbd_nextdata_n && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("pop_seen", kbd_nextdata_n, 0);
      chk("latency_before", evt_valid, 0);
      @(negedge clk);
      chk("latency_one_clk", evt_valid, 1);
    end
    drain();

    // Shifted letter and releases
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    drain();
    chk("shift_released", mods, 4'b0000);

    // CapsLock with autorepeat
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    drain();
    chk("caps_on", mods, 4'b1000);
    send(8'h58); send(8'hF0); send(8'h58);
    drain();
    chk("caps_off", mods, 4'b0000);

    // Ctrl letter, then an extended key
    send(8'h14); send(8'h21); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h75);
    drain();

    // Pause sequence swallowed
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h1C);
    drain();
    chk("pause_mods", mods, 4'b0000);

    // Back-pressure: first event held, no further pops
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #2;
    send(8'h1C); send(8'h32); send(8'h21);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("stall_valid", evt_valid, 1);
    chk("stall_code", evt_code, 8'h1C);
    chk("stall_fifo_left", rxq.size(), 2);
    ready_mode = 0;
    drain();

    // Reset in the middle of an E0 prefix
    send(8'h12); send(8'hE0);
    drain();
    @(posedge clk);
    #2 clr = 1'b1;
    rxq.delete();
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("clr_nextdata_n", kbd_nextdata_n, 1);
    chk("clr_evt_valid", evt_valid, 0);
    chk("clr_evt_code", evt_code, 0);
    chk("clr_evt_ascii", evt_ascii, 0);
    chk("clr_evt_flags", {evt_ext, evt_break}, 0);
    chk("clr_mods", mods, 0);
    @(posedge clk);
    #2 clr = 1'b0;
    send(8'h75);
    drain();

    // Randomized traffic with random consumer back-pressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      rand_token();
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    drain();
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
